// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: streams one image from memory into the CNN, then waits for NUM_CLASSES outputs.
// Define CNN_SEQ_ARGMAX_EN to track the winning class; otherwise result_idx/result_val stay at zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD   | issuing image-memory reads, one address per cycle
// S_DRAIN  | collecting remaining CNN outputs, bounded by the drain timer
// S_FINISH | one-cycle done pulse, frame counted
// S_ERROR  | one-cycle timeout pulse, frame not counted
module cnn_frame_sequencer #(
   parameter int NUM_PIXELS    = 784,
   parameter int PIX_W         = 8,
   parameter int OUT_W         = 32,
   parameter int NUM_CLASSES   = 10,
   parameter int DRAIN_TIMEOUT = 20000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   output logic                          img_rd_en,
   output logic [$clog2(NUM_PIXELS)-1:0] img_addr,
   input  logic [PIX_W-1:0]              img_data,
   output logic [PIX_W-1:0]              pixel_out,
   output logic                          pixel_valid,
   input  logic [OUT_W-1:0]              cnn_out,
   input  logic                          cnn_out_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout_err,
   output logic [3:0]                    result_idx,
   output logic [OUT_W-1:0]              result_val,
   output logic [15:0]                   frame_count
);
   localparam int AW = $clog2(NUM_PIXELS);
   localparam int CW = $clog2(NUM_CLASSES + 1);
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_PIXELS - 1);
   localparam logic [CW-1:0] CLASSES    = CW'(NUM_CLASSES);
   localparam logic [TW-1:0] DRAIN_LOAD = TW'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_FINISH, S_ERROR} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [TW-1:0]   drain_cnt_q, drain_cnt_d;
   logic            pixel_valid_q, pixel_valid_d;
   logic [15:0]     frame_count_q, frame_count_d;
   logic            start_frame, count_hit, outputs_done;

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Counter saturates at NUM_CLASSES so late extra valids never count.
   always_comb begin
      start_frame  = (state_q == S_IDLE) && start;
      count_hit    = cnn_out_valid && (state_q == S_LOAD || state_q == S_DRAIN)
                     && (out_cnt_q != CLASSES);
      out_cnt_d    = start_frame ? '0 : out_cnt_q + CW'(count_hit);
      outputs_done = (out_cnt_d == CLASSES);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD;
         S_LOAD:   if (abort) state_d = S_IDLE;
                   else if (addr_q == LAST_ADDR) state_d = S_DRAIN;
         S_DRAIN:  if (abort) state_d = S_IDLE;
                   else if (outputs_done) state_d = S_FINISH;
                   else if (drain_cnt_q == '0) state_d = S_ERROR;
         S_FINISH: state_d = S_IDLE;
         S_ERROR:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      img_rd_en   = (state_q == S_LOAD);
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_FINISH);
      timeout_err = (state_q == S_ERROR);
      img_addr    = addr_q;
      pixel_valid = pixel_valid_q;
      pixel_out   = pixel_valid_q ? img_data : '0;
      frame_count = frame_count_q;
   end

   // Drain timer is a down-counter loaded on DRAIN entry; zero is the terminal count.
   always_comb begin
      addr_d        = '0;
      drain_cnt_d   = '0;
      pixel_valid_d = (state_q == S_LOAD);
      frame_count_d = frame_count_q;
      if (state_q == S_LOAD && !abort) begin
         if (addr_q == LAST_ADDR) drain_cnt_d = DRAIN_LOAD;
         else                     addr_d      = addr_q + AW'(1);
      end
      if (state_q == S_DRAIN && drain_cnt_q != '0)
         drain_cnt_d = drain_cnt_q - TW'(1);
      if (state_q == S_FINISH)
         frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q        <= '0;
         out_cnt_q     <= '0;
         drain_cnt_q   <= '0;
         pixel_valid_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         addr_q        <= addr_d;
         out_cnt_q     <= out_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         pixel_valid_q <= pixel_valid_d;
         frame_count_q <= frame_count_d;
      end
   end

`ifdef CNN_SEQ_ARGMAX_EN
   localparam logic [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   logic [3:0]       result_idx_q, result_idx_d;
   logic [OUT_W-1:0] result_val_q, result_val_d;

   // Strictly-greater compare keeps the lower index on ties.
   always_comb begin
      result_idx_d = result_idx_q;
      result_val_d = result_val_q;
      if (start_frame) begin
         result_idx_d = '0;
         result_val_d = MOST_NEG;
      end else if (count_hit && ($signed(cnn_out) > $signed(result_val_q))) begin
         result_idx_d = 4'(out_cnt_q);
         result_val_d = cnn_out;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         result_idx_q <= '0;
         result_val_q <= '0;
      end else begin
         result_idx_q <= result_idx_d;
         result_val_q <= result_val_d;
      end
   end

   assign result_idx = result_idx_q;
   assign result_val = result_val_q;
`else
   logic cnn_out_unused;
   assign cnn_out_unused = ^cnn_out;
   assign result_idx     = '0;
   assign result_val     = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: directed frame scenarios with randomized pixels/outputs.
// Expected results come from frame-level rules (cycle positions, pixel totals, argmax over a list).
module tb_cnn_frame_sequencer;
   localparam int NP = 784;
   localparam int DT = 100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        img_rd_en;
   logic [9:0]  img_addr;
   logic [7:0]  img_data = 8'd0;
   logic [7:0]  pixel_out;
   logic        pixel_valid;
   logic [31:0] cnn_out = 32'd0;
   logic        cnn_out_valid = 1'b0;
   logic        busy, done, timeout_err;
   logic [3:0]  result_idx;
   logic [31:0] result_val;
   logic [15:0] frame_count;

   cnn_frame_sequencer #(
      .NUM_PIXELS(NP), .PIX_W(8), .OUT_W(32), .NUM_CLASSES(10), .DRAIN_TIMEOUT(DT)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
      .pixel_out(pixel_out), .pixel_valid(pixel_valid),
      .cnn_out(cnn_out), .cnn_out_valid(cnn_out_valid),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .result_idx(result_idx), .result_val(result_val), .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0]         mem [NP];
   logic signed [31:0] vals [12];
   int                 vcyc [12];
   int                 exp_fc = 0;

   // Synchronous image memory; junk on the bus when not reading.
   always @(posedge clock) img_data <= img_rd_en ? mem[img_addr] : 8'($urandom);

   int         pv_total = 0, pix_err = 0, done_total = 0, terr_total = 0;
   logic       prev_rd = 1'b0;
   logic [9:0] prev_addr = 10'd0;

   always @(negedge clock) begin
      if (img_rd_en && img_addr !== (prev_rd ? prev_addr + 10'd1 : 10'd0)) pix_err++;
      if (pixel_valid) begin
         pv_total++;
         if (!prev_rd || pixel_out !== mem[prev_addr]) pix_err++;
      end
      if (done) done_total++;
      if (timeout_err) terr_total++;
      prev_rd   <= img_rd_en;
      prev_addr <= img_addr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner over the first n counted outputs; zero when the comparator is not built.
   task automatic model(input int n, output logic [3:0] idx, output logic [31:0] val);
      logic signed [31:0] best;
      logic [3:0]         bi;
      best = 32'sh8000_0000;
      bi   = 4'd0;
      for (int i = 0; i < n; i++)
         if (vals[i] > best) begin
            best = vals[i];
            bi   = 4'(i);
         end
`ifdef CNN_SEQ_ARGMAX_EN
      idx = bi;
      val = best;
`else
      idx = 4'd0;
      val = 32'd0;
`endif
   endtask

   // c = 0 is the first LOAD cycle (address 0); c = 784 is the first DRAIN cycle.
   task automatic run_frame(input int first_v, input int nvalid, input int abort_c, input int rst_c,
                            input bit mid_starts, output int d_c, output int t_c, output int i_c);
      int sent;
      sent = 0; d_c = -1; t_c = -1; i_c = -1;
      cnn_out_valid = 1'b1;
      cnn_out       = 32'h7FFF_FFFF;
      @(posedge clock); #1;
      cnn_out_valid = 1'b0;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         if (done === 1'b1 && d_c < 0) d_c = c;
         if (timeout_err === 1'b1 && t_c < 0) t_c = c;
         if (busy === 1'b0 && i_c < 0) i_c = c;
         if (rst_c >= 0 && c == rst_c + 1) begin
            chk("rst_ctrl", 64'({busy, done, timeout_err, img_rd_en, img_addr, pixel_valid,
                                 pixel_out, result_idx}), 64'd0);
            chk("rst_data", 64'({result_val, frame_count}), 64'd0);
         end
         if (i_c >= 0 && c > i_c + 40) break;
         cnn_out_valid = 1'b0; abort = 1'b0; reset = 1'b0; start = 1'b0;
         if (sent < nvalid && c >= first_v && (c - first_v) % 7 == 0) begin
            cnn_out_valid = 1'b1;
            cnn_out       = vals[sent];
            vcyc[sent]    = c;
            sent++;
         end
         if (c == abort_c) abort = 1'b1;
         if (c == rst_c) reset = 1'b1;
         if (mid_starts && (c == 200 || c == 784)) start = 1'b1;
         @(posedge clock); #1;
      end
      cnn_out_valid = 1'b0; abort = 1'b0; reset = 1'b0; start = 1'b0;
   endtask

   task automatic clean_frame(input string tag, input int first_v, input bit mid_starts);
      int pv0 = pv_total, pe0 = pix_err, dn0 = done_total, te0 = terr_total;
      int d_c, t_c, i_c, exp_d;
      logic [3:0]  ei;
      logic [31:0] ev;
      run_frame(first_v, 12, -1, -1, mid_starts, d_c, t_c, i_c);
      exp_fc++;
      model(10, ei, ev);
      exp_d = (vcyc[9] + 1 > 785) ? vcyc[9] + 1 : 785;
      chk({tag, "_done_cycle"}, 64'(d_c), 64'(exp_d));
      chk({tag, "_done_pulses"}, 64'(done_total - dn0), 64'd1);
      chk({tag, "_terr_pulses"}, 64'(terr_total - te0), 64'd0);
      chk({tag, "_pixels"}, 64'(pv_total - pv0), 64'(NP));
      chk({tag, "_pixel_errs"}, 64'(pix_err - pe0), 64'd0);
      chk({tag, "_result_idx"}, 64'(result_idx), 64'(ei));
      chk({tag, "_result_val"}, 64'(result_val), 64'(ev));
      chk({tag, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
   endtask

   initial begin
      int pv0, dn0, te0, d_c, t_c, i_c;
      logic [3:0]  ei;
      logic [31:0] ev;
      logic signed [31:0] nominal [10];
      nominal = '{32'sd5, -32'sd3, 32'sd9, 32'sd9, 32'sd2, 32'sd0, 32'sd1, 32'sd1, -32'sd7, 32'sd4};

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("reset_ctrl", 64'({busy, done, timeout_err, img_rd_en, img_addr, pixel_valid,
                             pixel_out, result_idx}), 64'd0);
      chk("reset_data", 64'({result_val, frame_count}), 64'd0);
      @(posedge clock); #1;

      // Nominal frame: pixel = address, fixed output list.
      for (int i = 0; i < NP; i++) mem[i] = 8'(i);
      for (int i = 0; i < 10; i++) vals[i] = nominal[i];
      vals[10] = 32'sd100; vals[11] = 32'sd200;
      clean_frame("nominal", 10, 1'b0);
`ifdef CNN_SEQ_ARGMAX_EN
      chk("nominal_idx_const", 64'(result_idx), 64'd2);
      chk("nominal_val_const", 64'(result_val), 64'd9);
`else
      chk("nominal_idx_const", 64'(result_idx), 64'd0);
      chk("nominal_val_const", 64'(result_val), 64'd0);
`endif

      // Randomized frames; the second has start pulses during LOAD and DRAIN.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NP; i++) mem[i] = 8'($urandom);
         for (int i = 0; i < 12; i++)
            vals[i] = (f == 1) ? $signed(32'($urandom_range(0, 20))) - 32'sd10 : $signed(32'($urandom));
         clean_frame("random", $urandom_range(0, 800), f == 1);
      end

      for (int i = 0; i < 12; i++) vals[i] = -32'sd1;
      clean_frame("all_neg1", $urandom_range(0, 800), 1'b0);

      // Drain timeout: only nine outputs arrive.
      for (int i = 0; i < 12; i++) vals[i] = $signed(32'($urandom));
      pv0 = pv_total; dn0 = done_total; te0 = terr_total;
      run_frame($urandom_range(0, 800), 9, -1, -1, 1'b0, d_c, t_c, i_c);
      model(9, ei, ev);
      chk("timeout_cycle", 64'(t_c), 64'(NP + DT));
      chk("timeout_idle", 64'(i_c), 64'(NP + DT + 1));
      chk("timeout_terr_pulses", 64'(terr_total - te0), 64'd1);
      chk("timeout_done_pulses", 64'(done_total - dn0), 64'd0);
      chk("timeout_frame_count", 64'(frame_count), 64'(exp_fc));
      chk("timeout_partial_idx", 64'(result_idx), 64'(ei));
      chk("timeout_partial_val", 64'(result_val), 64'(ev));

      // Abort at LOAD address 300, then a clean frame.
      pv0 = pv_total; dn0 = done_total; te0 = terr_total;
      run_frame(10, 12, 300, -1, 1'b0, d_c, t_c, i_c);
      chk("abort_load_idle", 64'(i_c), 64'd301);
      chk("abort_load_pixels", 64'(pv_total - pv0), 64'd301);
      chk("abort_load_pulses", 64'((done_total - dn0) + (terr_total - te0)), 64'd0);
      chk("abort_load_frame_count", 64'(frame_count), 64'(exp_fc));
      for (int i = 0; i < 12; i++) vals[i] = $signed(32'($urandom));
      clean_frame("after_abort", $urandom_range(0, 800), 1'b0);

      // Abort in the same DRAIN cycle as the tenth output: abort wins.
      pv0 = pv_total; dn0 = done_total; te0 = terr_total;
      run_frame(790, 12, 853, -1, 1'b0, d_c, t_c, i_c);
      chk("abort_drain_idle", 64'(i_c), 64'd854);
      chk("abort_drain_pixels", 64'(pv_total - pv0), 64'(NP));
      chk("abort_drain_pulses", 64'((done_total - dn0) + (terr_total - te0)), 64'd0);
      chk("abort_drain_frame_count", 64'(frame_count), 64'(exp_fc));

      // Reset at DRAIN cycle 10; later outputs must be ignored.
      pv0 = pv_total; dn0 = done_total; te0 = terr_total;
      run_frame(760, 12, -1, NP + 10, 1'b0, d_c, t_c, i_c);
      exp_fc = 0;
      chk("reset_drain_idle", 64'(i_c), 64'(NP + 11));
      chk("reset_drain_pulses", 64'((done_total - dn0) + (terr_total - te0)), 64'd0);
      chk("reset_drain_pixels", 64'(pv_total - pv0), 64'(NP));
      chk("reset_drain_result", 64'({result_idx, result_val}), 64'd0);
      chk("reset_drain_frame_count", 64'(frame_count), 64'd0);
      clean_frame("after_reset", $urandom_range(0, 800), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
